// File: rtl/array_mult_dot_accumulator.sv
// Dot-product accumulator around an external 4x4 array multiplier: operand pairs
// are registered onto mul_a/mul_b, products summed over LEN terms, result handed off.
module array_mult_dot_accumulator #(
  parameter int LEN   = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             flush,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic [3:0]       count,
  output logic             ovf
);

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(LEN - 1);

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic             last_reg, last_next;
  logic             ovf_acc_reg, ovf_acc_next;
  logic [3:0]       mul_a_reg, mul_a_next;
  logic [3:0]       mul_b_reg, mul_b_next;
  logic [ACC_W-1:0] result_reg, result_next;
  logic [3:0]       count_reg, count_next;
  logic             ovf_reg, ovf_next;
  logic [ACC_W:0]   sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ACC;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      last_reg    <= 1'b0;
      ovf_acc_reg <= 1'b0;
      mul_a_reg   <= '0;
      mul_b_reg   <= '0;
      result_reg  <= '0;
      count_reg   <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      last_reg    <= last_next;
      ovf_acc_reg <= ovf_acc_next;
      mul_a_reg   <= mul_a_next;
      mul_b_reg   <= mul_b_next;
      result_reg  <= result_next;
      count_reg   <= count_next;
      ovf_reg     <= ovf_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    last_next    = last_reg;
    ovf_acc_next = ovf_acc_reg;
    mul_a_next   = mul_a_reg;
    mul_b_next   = mul_b_reg;
    result_next  = result_reg;
    count_next   = count_reg;
    ovf_next     = ovf_reg;
    // One extra bit so the carry out of the accumulator is visible.
    sum          = {1'b0, acc_reg} + {{(ACC_W + 1 - 8){1'b0}}, mul_p};

    case (state_reg)
      ACC: begin
        if (in_valid) begin
          mul_a_next = in_a;
          mul_b_next = in_b;
          last_next  = flush | (cnt_reg == LAST_IDX);
          state_next = MUL;
        end else if (flush && (cnt_reg != 4'd0)) begin
          result_next = acc_reg;
          count_next  = cnt_reg;
          ovf_next    = ovf_acc_reg;
          state_next  = DONE;
        end
      end
      MUL: begin
        acc_next     = sum[ACC_W-1:0];
        cnt_next     = cnt_reg + 4'd1;
        ovf_acc_next = ovf_acc_reg | sum[ACC_W];
        if (last_reg) begin
          result_next = sum[ACC_W-1:0];
          count_next  = cnt_reg + 4'd1;
          ovf_next    = ovf_acc_reg | sum[ACC_W];
          state_next  = DONE;
        end else begin
          state_next = ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_next     = '0;
          cnt_next     = '0;
          ovf_acc_next = 1'b0;
          state_next   = ACC;
        end
      end
      default: state_next = ACC;
    endcase
  end

  assign in_ready  = (state_reg == ACC);
  assign out_valid = (state_reg == DONE);
  assign mul_a     = mul_a_reg;
  assign mul_b     = mul_b_reg;
  assign result    = result_reg;
  assign count     = count_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_array_mult_dot_accumulator.sv
// Directed bench for array_mult_dot_accumulator; an ACC_W=8 copy shares stimulus
// to exercise accumulator wrap and the sticky overflow flag.
module tb_array_mult_dot_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready, ovf;
  logic [3:0]  in_a, in_b, mul_a, mul_b, count;
  logic [7:0]  mul_p;
  logic [11:0] result;

  logic        in_ready8, out_valid8, ovf8;
  logic [3:0]  mul_a8, mul_b8, count8;
  logic [7:0]  mul_p8, result8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign mul_p  = mul_a * mul_b;
  assign mul_p8 = mul_a8 * mul_b8;

  array_mult_dot_accumulator #(.LEN(4), .ACC_W(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .flush(flush), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .count(count), .ovf(ovf)
  );

  array_mult_dot_accumulator #(.LEN(4), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .in_a(in_a), .in_b(in_b), .flush(flush), .mul_a(mul_a8), .mul_b(mul_b8),
    .mul_p(mul_p8), .out_valid(out_valid8), .out_ready(out_ready),
    .result(result8), .count(count8), .ovf(ovf8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Waits (bounded) for in_ready, presents one pair for one cycle, then checks
  // that the block is busy in its multiply cycle.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic fl);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    flush    = fl;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    in_a     = 4'hx;
    in_b     = 4'hx;
    check("in_ready_busy", 32'(in_ready), 32'd0);
  endtask

  // Called one cycle after the final accept: out_valid must rise exactly one cycle later.
  task automatic expect_result(input logic [11:0] r, input logic [3:0] c, input logic o);
    check("out_valid_pre", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'd1);
    check("result", 32'(result), 32'(r));
    check("count", 32'(count), 32'(c));
    check("ovf", 32'(ovf), 32'(o));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; flush = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_result", 32'(result), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic vector: 8+30+4+70.
    send(4'd4, 4'd2, 1'b0);
    check("mul_a_latched", 32'(mul_a), 32'd4);
    check("mul_p_seen", 32'(mul_p), 32'd8);
    @(negedge clk);
    check("in_ready_acc", 32'(in_ready), 32'd1);
    send(4'd5, 4'd6, 1'b0);
    send(4'd4, 4'd1, 1'b0);
    send(4'd5, 4'd14, 1'b0);
    expect_result(12'd112, 4'd4, 1'b0);
    @(negedge clk);
    check("consumed", 32'(out_valid), 32'd0);

    // Four 225s: 900 at 12 bits; 900 mod 256 = 132 with carry at 8 bits.
    repeat (4) send(4'd15, 4'd15, 1'b0);
    expect_result(12'd900, 4'd4, 1'b0);
    check("w8_out_valid", 32'(out_valid8), 32'd1);
    check("w8_result", 32'(result8), 32'd132);
    check("w8_count", 32'(count8), 32'd4);
    check("w8_ovf", 32'(ovf8), 32'd1);
    @(negedge clk);

    // Flush on the accepting cycle of the second pair: 54+225.
    send(4'd6, 4'd9, 1'b0);
    send(4'd15, 4'd15, 1'b1);
    expect_result(12'd279, 4'd2, 1'b0);
    @(negedge clk);

    // Flush alone after one pair.
    send(4'd5, 4'd10, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd1);
    check("flush_result", 32'(result), 32'd50);
    check("flush_count", 32'(count), 32'd1);
    @(negedge clk);

    // Backpressure: 2+12+4+0 held while in_valid is waved at it.
    out_ready = 1'b0;
    send(4'd1, 4'd2, 1'b0);
    send(4'd3, 4'd4, 1'b0);
    send(4'd2, 4'd2, 1'b0);
    send(4'd0, 4'd9, 1'b0);
    expect_result(12'd18, 4'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 4'd7; in_b = 4'd7;
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_result", 32'(result), 32'd18);
      check("bp_count", 32'(count), 32'd4);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_released", 32'(out_valid), 32'd0);
    send(4'd2, 4'd3, 1'b0);
    send(4'd1, 4'd1, 1'b0);
    send(4'd1, 4'd1, 1'b0);
    send(4'd1, 4'd1, 1'b0);
    expect_result(12'd9, 4'd4, 1'b0);
    @(negedge clk);

    // Asynchronous reset after two of four pairs.
    send(4'd9, 4'd9, 1'b0);
    send(4'd8, 4'd8, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_mul_a", 32'(mul_a), 32'd0);
    check("arst_mul_b", 32'(mul_b), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    repeat (4) send(4'd1, 4'd1, 1'b0);
    expect_result(12'd4, 4'd4, 1'b0);
    @(negedge clk);

    // Asynchronous reset while a result is waiting.
    out_ready = 1'b0;
    repeat (4) send(4'd3, 4'd3, 1'b0);
    expect_result(12'd36, 4'd4, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_done_valid", 32'(out_valid), 32'd0);
    check("arst_done_result", 32'(result), 32'd0);
    check("arst_done_count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // Flush with nothing accumulated, then long gaps between pairs: 9+14+4+6.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush0_out_valid", 32'(out_valid), 32'd0);
    check("flush0_in_ready", 32'(in_ready), 32'd1);
    send(4'd3, 4'd3, 1'b0);
    for (int i = 0; i < 10; i++) @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    send(4'd2, 4'd7, 1'b0);
    repeat (10) @(negedge clk);
    send(4'd1, 4'd4, 1'b0);
    send(4'd6, 4'd1, 1'b0);
    expect_result(12'd33, 4'd4, 1'b0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
